ring0_sequencer: RTL
====================

# ring0_sequencer

Measurement sequencer for the collapsing ring-oscillator macro. Sits in the digital core between the register/LA interface and the `ring0_*` nets that drive the ring macro. A single `go` request runs this sequence:

- Apply the trim and clock-mux configuration and let it settle.
- Fire `start`.
- Count synchronized ring-clock edges until the ring collapses or the measurement window expires.
- Return the result through a valid/ready handshake.

## Interface
Parameters:
- `CNT_W`, default 16: width of the edge counter (saturating).
- `WIN_W`, default 16: width of the window and cycle counters.
- `SETTLE_CYC`, default 8: cycles the trims are held stable before `start` rises.
- `IDLE_TO`, default 64: consecutive edge-free RUN cycles that declare a collapse.

Ports:
- `wb_clk_i`  in  1  the only clock.
- `wb_rst_ni`  in  1  reset, asynchronous assert, active-low.
- `go_i`  in  1  single-cycle request; accepted only in IDLE.
- `abort_i`  in  1  cancels the run from ARM, RUN or STOP.
- `busy_o`  out  1  high from ARM through DONE.
- `cfg_trim_a_i`  in  28  trim A, latched at accept.
- `cfg_trim_b_i`  in  28  trim B, latched at accept.
- `cfg_clkmux_i`  in  3  ring output divider select, latched at accept.
- `cfg_window_i`  in  WIN_W  RUN length in clock cycles, latched at accept.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  result consumed.
- `res_count_o`  out  CNT_W  detected ring rising edges.
- `res_cycles_o`  out  WIN_W  RUN cycle index of the last detected edge.
- `res_collapsed_o`  out  1  run ended by collapse, not by window expiry.
- `ring0_clk_i`  in  1  ring output; asynchronous.
- `ring0_start_o`  out  1  ring start.
- `ring0_trim_a_o`  out  28  ring trim A.
- `ring0_trim_b_o`  out  28  ring trim B.
- `ring0_clkmux_o`  out  3  ring divider select.

## Operation
- **Reset values:** every output is 0, the FSM is in IDLE and the synchronizer flops are 0.
- **Edge detect:** `ring0_clk_i` passes through a 2-flop synchronizer plus one history flop. A rising edge is s2 & ~s3.
  - Software must pick `clkmux` so that the selected ring frequency is below f_clk/2.
  - Faster ring outputs alias, and the resulting counts are undefined but the FSM stays safe.
- **IDLE:** `go_i` latches all `cfg_*` inputs. The `ring0_trim*` and `ring0_clkmux` outputs update only at accept and hold until the next accept.
- **ARM:** runs for `SETTLE_CYC` cycles with start=0. The edge counter, cycle counter, last-edge register and idle counter are all cleared.
- **RUN:**
  - start=1 for the whole state.
  - The cycle counter increments every cycle.
  - Each detected edge increments the count (saturating at all-ones), records the current cycle index into `res_cycles`, and clears the idle counter.
  - Exits when the idle counter reaches `IDLE_TO` (collapsed=1) or the cycle counter reaches `cfg_window` (collapsed=0).
  - If both conditions hit in the same cycle, collapse wins.
- **STOP:** runs for 3 cycles with start=0. Edges still arriving from the synchronizer pipeline are counted, but the cycle counter is frozen.
- **DONE:** `res_valid_o`=1 and the result holds until the cycle `res_ready_i` is high, then the FSM returns to IDLE. `go_i` is ignored while busy.
- **window = 0:** ARM is followed directly by DONE. start is never asserted, and the result is count=0, cycles=0, collapsed=0.
- **No edges at all in RUN:** the run collapses after `IDLE_TO` cycles with count=0 and cycles=0.
- **abort_i in ARM, RUN or STOP:** the FSM goes to IDLE next cycle, start drops the same edge, and no result is produced. Trims keep their values. `abort_i` is ignored in IDLE and DONE.
- **Asynchronous reset mid-run:** all outputs immediately take their reset values, including start=0 and trims=0.

## Timing
- `go_i` sampled high at edge 0 ⇒ `busy_o`=1 and trims valid after edge 0.
- ARM occupies cycles 1..SETTLE_CYC.
- `ring0_start_o` rises after edge SETTLE_CYC and stays high for exactly `cfg_window` cycles (or fewer on collapse).
- STOP follows for 3 cycles.
- `res_valid_o` rises after edge SETTLE_CYC + window + 3.
- Handshake completes on the edge where valid and ready are both high; `busy_o` falls with it.
- The earliest next `go_i` accept is the cycle after return to IDLE.
- Edge-to-count latency is 3 cycles.
- All outputs are registered.

## Test plan
- **Steady ring:** ring period 10 clocks, clkmux=0, window=1000, ready tied high ⇒ count=100±1, collapsed=0, start high for exactly 1000 cycles.
- **Collapse:** ring emits 37 edges then stops, window=10000 ⇒ count=37, collapsed=1, cycles=index of the 37th edge, RUN exits 64 cycles after the last edge.
- **Dead ring and window=0:**
  - No ring edges ⇒ collapsed=1, count=0 after 64 RUN cycles.
  - window=0 ⇒ start never asserted, valid with an all-zero result after SETTLE_CYC+1 cycles.
- **Abort and re-accept:** `abort_i` in RUN cycle 50 ⇒ start low next cycle, `busy_o`=0, no `res_valid_o`; a following `go_i` runs a full sequence correctly.
- **Backpressure:** hold `res_ready_i` low for 20 cycles and pulse `go_i` meanwhile ⇒ result stable, go ignored, release completes with one transfer.
- **Saturation and reset:**
  - CNT_W=4 with 30 edges ⇒ count=15.
  - Assert `wb_rst_ni` low mid-RUN ⇒ start, trims and valid go to 0 asynchronously.

Source files
------------

// File: rtl/ring0_sequencer_if.sv
// Control and result bus between the register/LA block and ring0_sequencer.
// The sequencer connects through the slave modport; the register side
// connects through the master modport.
interface ring0_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic             go_i;
    logic             abort_i;
    logic             busy_o;
    logic [27:0]      cfg_trim_a_i;
    logic [27:0]      cfg_trim_b_i;
    logic [2:0]       cfg_clkmux_i;
    logic [WIN_W-1:0] cfg_window_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [CNT_W-1:0] res_count_o;
    logic [WIN_W-1:0] res_cycles_o;
    logic             res_collapsed_o;

    modport slave (
        input  go_i, abort_i, cfg_trim_a_i, cfg_trim_b_i, cfg_clkmux_i,
               cfg_window_i, res_ready_i,
        output busy_o, res_valid_o, res_count_o, res_cycles_o, res_collapsed_o
    );

    modport master (
        output go_i, abort_i, cfg_trim_a_i, cfg_trim_b_i, cfg_clkmux_i,
               cfg_window_i, res_ready_i,
        input  busy_o, res_valid_o, res_count_o, res_cycles_o, res_collapsed_o
    );
endinterface

// File: rtl/ring0_sequencer.sv
// Measurement sequencer for the collapsing ring-oscillator macro.
// One go request applies trims, waits for them to settle, starts the ring,
// counts synchronized ring edges until collapse or window expiry, and hands
// the result back over a valid/ready handshake.
module ring0_sequencer #(
    parameter int CNT_W      = 16,
    parameter int WIN_W      = 16,
    parameter int SETTLE_CYC = 8,
    parameter int IDLE_TO    = 64
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    ring0_sequencer_if.slave        bus,
    input  logic                    ring0_clk_i,
    output logic                    ring0_start_o,
    output logic [27:0]             ring0_trim_a_o,
    output logic [27:0]             ring0_trim_b_o,
    output logic [2:0]              ring0_clkmux_o
);

    // One timer serves both the ARM settle period and the 3-cycle STOP drain.
    localparam int TMR_MAX = (SETTLE_CYC > 3) ? SETTLE_CYC : 3;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int IDLE_W  = $clog2(IDLE_TO + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_RUN,
        S_STOP,
        S_DONE
    } state_t;

    state_t             state_q,     state_d;
    logic [TMR_W-1:0]   tmr_q,       tmr_d;
    logic               ring_s1_q,   ring_s1_d;
    logic               ring_s2_q,   ring_s2_d;
    logic               ring_s3_q,   ring_s3_d;
    logic [CNT_W-1:0]   cnt_q,       cnt_d;
    logic [WIN_W-1:0]   cyc_q,       cyc_d;
    logic [WIN_W-1:0]   last_q,      last_d;
    logic [IDLE_W-1:0]  idle_q,      idle_d;
    logic               collapsed_q, collapsed_d;
    logic [27:0]        trim_a_q,    trim_a_d;
    logic [27:0]        trim_b_q,    trim_b_d;
    logic [2:0]         clkmux_q,    clkmux_d;
    logic [WIN_W-1:0]   window_q,    window_d;
    logic               start_q,     start_d;
    logic               busy_q,      busy_d;
    logic               valid_q,     valid_d;

    logic               edge_det;
    logic [WIN_W-1:0]   cyc_inc;
    logic [IDLE_W-1:0]  idle_inc;
    logic               cnt_full;

    assign edge_det = ring_s2_q & ~ring_s3_q;
    assign cyc_inc  = cyc_q + 1'b1;
    assign idle_inc = idle_q + 1'b1;
    assign cnt_full = (cnt_q == {CNT_W{1'b1}});

    // Next-state, counter and registered-output logic for the measurement FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        tmr_d       = tmr_q;
        ring_s1_d   = ring0_clk_i;
        ring_s2_d   = ring_s1_q;
        ring_s3_d   = ring_s2_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        last_d      = last_q;
        idle_d      = idle_q;
        collapsed_d = collapsed_q;
        trim_a_d    = trim_a_q;
        trim_b_d    = trim_b_q;
        clkmux_d    = clkmux_q;
        window_d    = window_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.go_i) begin
                    trim_a_d = bus.cfg_trim_a_i;
                    trim_b_d = bus.cfg_trim_b_i;
                    clkmux_d = bus.cfg_clkmux_i;
                    window_d = bus.cfg_window_i;
                    tmr_d    = '0;
                    state_d  = S_ARM;
                end
            end
            S_ARM: begin
                cnt_d       = '0;
                cyc_d       = '0;
                last_d      = '0;
                idle_d      = '0;
                collapsed_d = 1'b0;
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else if (tmr_q == TMR_W'(SETTLE_CYC - 1)) begin
                    tmr_d   = '0;
                    state_d = (window_q == '0) ? S_DONE : S_RUN;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            S_RUN: begin
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    cyc_d = cyc_inc;
                    if (edge_det) begin
                        if (!cnt_full) cnt_d = cnt_q + 1'b1;
                        last_d = cyc_q;
                        idle_d = '0;
                    end else begin
                        idle_d = idle_inc;
                    end
                    // Collapse is tested first so it wins a tie with the window.
                    if (!edge_det && (idle_inc == IDLE_W'(IDLE_TO))) begin
                        collapsed_d = 1'b1;
                        tmr_d       = '0;
                        state_d     = S_STOP;
                    end else if (cyc_inc == window_q) begin
                        tmr_d   = '0;
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                // Edges still in the synchronizer are counted; the index freezes.
                if (bus.abort_i) begin
                    state_d = S_IDLE;
                end else begin
                    if (edge_det && !cnt_full) cnt_d = cnt_q + 1'b1;
                    if (tmr_q == TMR_W'(2)) begin
                        state_d = S_DONE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (bus.res_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Status outputs are decoded from the next state so they are flops.
        start_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    // State and datapath registers; async reset clears every output.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            ring_s1_q   <= 1'b0;
            ring_s2_q   <= 1'b0;
            ring_s3_q   <= 1'b0;
            cnt_q       <= '0;
            cyc_q       <= '0;
            last_q      <= '0;
            idle_q      <= '0;
            collapsed_q <= 1'b0;
            trim_a_q    <= '0;
            trim_b_q    <= '0;
            clkmux_q    <= '0;
            window_q    <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            ring_s1_q   <= ring_s1_d;
            ring_s2_q   <= ring_s2_d;
            ring_s3_q   <= ring_s3_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            last_q      <= last_d;
            idle_q      <= idle_d;
            collapsed_q <= collapsed_d;
            trim_a_q    <= trim_a_d;
            trim_b_q    <= trim_b_d;
            clkmux_q    <= clkmux_d;
            window_q    <= window_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    assign ring0_start_o       = start_q;
    assign ring0_trim_a_o      = trim_a_q;
    assign ring0_trim_b_o      = trim_b_q;
    assign ring0_clkmux_o      = clkmux_q;
    assign bus.busy_o          = busy_q;
    assign bus.res_valid_o     = valid_q;
    assign bus.res_count_o     = cnt_q;
    assign bus.res_cycles_o    = last_q;
    assign bus.res_collapsed_o = collapsed_q;

endmodule
